// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit writing the architectural HI/LO pair.
// The divide datapath exists only when MULDIV_DIV_EN is defined; otherwise divide ops complete as no-ops.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        rd_req,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned ACCW = 2 * XLEN;
    localparam int unsigned CNTW = 5;
    localparam logic [CNTW-1:0] LASTITER = CNTW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic            launch;
    logic            iterate;
    logic            finish;
    logic            mtWrite;
    logic            skipCalc;
    logic            isDiv;
    logic            negRes;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] opnd;
    logic [ACCW-1:0] acc;

    logic            aNeg;
    logic            bNeg;
    logic [XLEN-1:0] absA;
    logic [XLEN-1:0] absB;
    logic [XLEN:0]   mulSum;
    logic [ACCW-1:0] mulStep;
    logic [ACCW-1:0] product;

    // Signed ops run on magnitudes; the sign is restored in FIX.
    assign aNeg = op[0] & opA[XLEN-1];
    assign bNeg = op[0] & opB[XLEN-1];
    assign absA = aNeg ? -opA : opA;
    assign absB = bNeg ? -opB : opB;

    // acc = {partial product, remaining multiplier bits}; one shift-add per cycle.
    assign mulSum  = {1'b0, acc[ACCW-1:XLEN]} + {1'b0, opnd};
    assign mulStep = acc[0] ? {mulSum, acc[XLEN-1:1]} : {1'b0, acc[ACCW-1:1]};
    assign product = negRes ? -acc : acc;

`ifdef MULDIV_DIV_EN
    logic            negRem;
    logic            divZero;
    logic            divGe;
    logic [XLEN:0]   divShift;
    logic [XLEN-1:0] divRem;
    logic [ACCW-1:0] divStep;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    // acc = {remainder, dividend/quotient}; restoring shift-subtract, quotient bits enter at the LSB.
    assign divShift = {acc[ACCW-1:XLEN], acc[XLEN-1]};
    assign divGe    = divShift >= {1'b0, opnd};
    assign divRem   = divGe ? (divShift[XLEN-1:0] - opnd) : divShift[XLEN-1:0];
    assign divStep  = {divRem, acc[XLEN-2:0], divGe};
    assign quot     = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem      = negRem ? -acc[ACCW-1:XLEN] : acc[ACCW-1:XLEN];
    assign skipCalc = op[1] & (opB == '0);
`else
    assign skipCalc = op[1];
`endif

    assign stall = busy & (rd_req | start);

    always_comb begin : fsmNext
        stateNext = state;
        launch    = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        mtWrite   = 1'b0;
        case (state)
            IDLE: begin
                mtWrite = ~start;
                if (start) begin
                    launch    = 1'b1;
                    stateNext = skipCalc ? FIX : CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (cnt == '0) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                finish    = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Abort wins over every transition, including a launch from IDLE.
        if (flush) begin
            stateNext = IDLE;
            launch    = 1'b0;
            iterate   = 1'b0;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : stateReg
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : datapath
        if (!reset) begin
            cnt    <= '0;
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
`ifdef MULDIV_DIV_EN
            negRem  <= 1'b0;
            divZero <= 1'b0;
`endif
        end else if (launch) begin
            cnt    <= LASTITER;
            isDiv  <= op[1];
            negRes <= aNeg ^ bNeg;
`ifdef MULDIV_DIV_EN
            negRem  <= aNeg;
            divZero <= skipCalc;
            if (skipCalc) begin
                acc  <= {XLEN'(0), opA};
                opnd <= opB;
            end else if (op[1]) begin
                acc  <= {XLEN'(0), absA};
                opnd <= absB;
            end else begin
                acc  <= {XLEN'(0), absB};
                opnd <= absA;
            end
`else
            acc  <= {XLEN'(0), absB};
            opnd <= absA;
`endif
        end else if (iterate) begin
            cnt <= cnt - CNTW'(1);
`ifdef MULDIV_DIV_EN
            acc <= isDiv ? divStep : mulStep;
`else
            acc <= mulStep;
`endif
        end
    end

    // HI/LO, status flags; completion and MTHI/MTLO writes never coincide (FIX vs IDLE).
    always_ff @(posedge clk or negedge reset) begin : results
        if (!reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            div0 <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= finish;
            busy <= (stateNext != IDLE);
            if (finish) begin
`ifdef MULDIV_DIV_EN
                div0 <= divZero;
                if (divZero) begin
                    hi <= acc[XLEN-1:0];
                    lo <= '1;
                end else if (isDiv) begin
                    hi <= rem;
                    lo <= quot;
                end else begin
                    hi <= product[ACCW-1:XLEN];
                    lo <= product[XLEN-1:0];
                end
`else
                div0 <= 1'b0;
                if (!isDiv) begin
                    hi <= product[ACCW-1:XLEN];
                    lo <= product[XLEN-1:0];
                end
`endif
            end else if (mtWrite) begin
                if (mthi) begin
                    hi <= wdata;
                end
                if (mtlo) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed operations against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        rd_req;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        mBusy  = 1'b0;
    logic        mDone  = 1'b0;
    logic        mDiv0  = 1'b0;
    logic [31:0] mHi    = '0;
    logic [31:0] mLo    = '0;
    logic [31:0] pHi    = '0;
    logic [31:0] pLo    = '0;
    logic        pDiv0  = 1'b0;
    logic        pWr    = 1'b0;
    int          remain = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .rd_req (rd_req),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .div0   (div0),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic calcResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl,
                              output logic d0, output logic wr, output int lat);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        rh  = '0;
        rl  = '0;
        d0  = 1'b0;
        wr  = 1'b1;
        lat = 33;
        if (!o[1]) begin
            if (o[0]) p = 64'(sa * sb);
            else      p = {32'd0, a} * {32'd0, b};
            rh = p[63:32];
            rl = p[31:0];
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
                rl  = 32'hFFFF_FFFF;
                rh  = a;
                d0  = 1'b1;
                lat = 1;
            end else if (o[0]) begin
                rl = 32'(sa / sb);
                rh = 32'(sa % sb);
            end else begin
                rl = a / b;
                rh = a % b;
            end
`else
            wr  = 1'b0;
            lat = 1;
`endif
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mBusy  = 1'b0;
                mDone  = 1'b0;
                mDiv0  = 1'b0;
                mHi    = '0;
                mLo    = '0;
                remain = 0;
            end else begin
                mDone = 1'b0;
                if (mBusy) begin
                    if (flush) begin
                        mBusy = 1'b0;
                    end else begin
                        remain--;
                        if (remain == 0) begin
                            mBusy = 1'b0;
                            mDone = 1'b1;
                            mDiv0 = pDiv0;
                            if (pWr) begin
                                mHi = pHi;
                                mLo = pLo;
                            end
                        end
                    end
                end else if (start && !flush) begin
                    calcResult(op, opA, opB, pHi, pLo, pDiv0, pWr, remain);
                    mBusy = 1'b1;
                end else if (!start) begin
                    if (mthi) mHi = wdata;
                    if (mtlo) mLo = wdata;
                end
            end
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_busy", busy, mBusy);
            chk("cyc_done", done, mDone);
            chk("cyc_div0", div0, mDiv0);
            chk("cyc_hi", hi, mHi);
            chk("cyc_lo", lo, mLo);
            chk("cyc_stall", stall, mBusy & (rd_req | start));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCyc);
        lat     = 0;
        busyCyc = busy ? 1 : 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busyCyc++;
        end
        checks++;
        if (lat == 0) begin
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_100");
        end
    endtask

    initial begin : stimulus
        int lat;
        int bc;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        opA    = '0;
        opB    = '0;
        rd_req = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;
        flush  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        issue(2'b00, 32'd7, 32'd6);
        waitDone(lat, bc);
        chk("multu_lat", lat, 33);
        chk("multu_hilo", {hi, lo}, 64'd42);

        issue(2'b00, 32'd5, 32'd5);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        issue(2'b01, 32'hFFFF_FFFE, 32'd3);
        waitDone(lat, bc);
        chk("mult_lat", lat, 33);
        chk("mult_busycyc", bc, 33);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

`ifdef MULDIV_DIV_EN
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        waitDone(lat, bc);
        chk("div_lat", lat, 33);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(lat, bc);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        issue(2'b10, 32'h1234, 32'd0);
        waitDone(lat, bc);
        chk("divz_lat", lat, 1);
        chk("divz_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        chk("divz_flag", div0, 1);
        issue(2'b10, 32'd10, 32'd3);
        waitDone(lat, bc);
        chk("divu_lat", lat, 33);
        chk("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);
        chk("divu_flag", div0, 0);
        issue(2'b11, 32'hFFFF_FFF9, 32'd0);
        waitDone(lat, bc);
        chk("divz_s_hilo", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
        chk("divz_s_flag", div0, 1);
`else
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        waitDone(lat, bc);
        chk("nodiv_lat", lat, 1);
        chk("nodiv_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("nodiv_flag", div0, 0);
        issue(2'b10, 32'h1234, 32'd0);
        waitDone(lat, bc);
        chk("nodivz_lat", lat, 1);
        chk("nodivz_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("nodivz_flag", div0, 0);
`endif

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(lat, bc);
        chk("mult_negneg", {hi, lo}, 64'd1);
        chk("mult_div0clr", div0, 0);
        issue(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        waitDone(lat, bc);
        chk("mult_max", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        rd_req = 1'b1;
        start  = 1'b1;
        op     = 2'b10;
        opA    = 32'd100;
        opB    = 32'd7;
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", stall, 1);
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        rd_req = 1'b0;
        waitDone(lat, bc);
        chk("stall_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_nolaunch", busy, 0);
        chk("stall_idle", stall, 0);
        rd_req = 1'b0;

        issue(2'b00, 32'd3, 32'd3);
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
        repeat (3) @(posedge clk);
        #1;

        mthi  = 1'b1;
        wdata = 32'hAAAA_0000;
        @(posedge clk);
        #1 mthi = 1'b0;
        chk("mthi_idle", {hi, lo}, 64'hAAAA_0000_0000_0000);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mthilo_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

        issue(2'b00, 32'd2, 32'd2);
        mtlo  = 1'b1;
        wdata = 32'h0000_5555;
        repeat (3) @(posedge clk);
        #1 mtlo = 1'b0;
        chk("mtlo_busy", lo, 32'hCAFE_F00D);
        waitDone(lat, bc);
        chk("mtlo_busy_res", {hi, lo}, 64'd4);

        mthi  = 1'b1;
        wdata = 32'h1234_5678;
        issue(2'b00, 32'd2, 32'hFFFF_FFFF);
        mthi = 1'b0;
        chk("mthi_start_hi", hi, 32'd0);
        chk("mthi_start_busy", busy, 1);
        waitDone(lat, bc);
        chk("mthi_start_lat", lat, 33);
        chk("mthi_start_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        issue(2'b01, 32'hFFFF_FFF6, 32'd10);
        waitDone(lat, bc);
        chk("b2b_lat", lat, 33);
        chk("b2b_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FF9C);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
